// File: rtl/fifo_reg.sv
// fifo_reg: 4-entry shift-register FIFO with every storage slot exported.
// reg0 is always the head (oldest entry). A pop shifts all slots down by one.
// Optional feature macro: FIFO_REG_CLEAR_ON_POP_EN. When defined, the slot
// vacated by a pop is zeroed, so unused slots read 0. When undefined, that
// slot keeps its stale value.
module fifo_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic             en,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3
);

  logic [WIDTH-1:0] r_slot [0:3];
  logic [2:0]       r_count;
  logic             r_en;
  logic [WIDTH-1:0] r_data_out;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic [1:0]       w_wr_idx;
  logic [1:0]       w_tail_idx;

  // Accept decode; a push into a full FIFO is allowed only alongside a pop.
  // When the FIFO is empty the pop is refused, so there is no bypass path.
  always_comb begin
    w_pop_ok   = pop & (r_count != 3'd0);
    w_push_ok  = push & ((r_count != 3'd4) | w_pop_ok);
    // First free slot; only used when count < 4.
    w_wr_idx   = r_count[1:0];
    // Current tail slot; count 4 wraps to index 3, which is intended.
    w_tail_idx = r_count[1:0] - 2'd1;
  end

  // Storage, read register, strobe and occupancy; reset overrides push/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_slot[i] <= '0;
      r_count    <= 3'd0;
      r_en       <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_en <= w_pop_ok;
      if (w_pop_ok) begin
        r_data_out <= r_slot[0];
        r_slot[0]  <= r_slot[1];
        r_slot[1]  <= r_slot[2];
        r_slot[2]  <= r_slot[3];
        // The old tail position either takes the new data or is vacated.
        if (w_push_ok) begin
          r_slot[w_tail_idx] <= data_in;
        end else begin
`ifdef FIFO_REG_CLEAR_ON_POP_EN
          r_slot[w_tail_idx] <= '0;
`else
          r_count <= r_count - 3'd1;
`endif
        end
`ifdef FIFO_REG_CLEAR_ON_POP_EN
        if (!w_push_ok) r_count <= r_count - 3'd1;
`endif
      end else if (w_push_ok) begin
        r_slot[w_wr_idx] <= data_in;
        r_count          <= r_count + 3'd1;
      end
    end
  end

  // Flags decode the registered count directly.
  always_comb begin
    fifo_full  = (r_count == 3'd4);
    fifo_empty = (r_count == 3'd0);
  end

  assign en       = r_en;
  assign data_out = r_data_out;
  assign reg0     = r_slot[0];
  assign reg1     = r_slot[1];
  assign reg2     = r_slot[2];
  assign reg3     = r_slot[3];

endmodule

// File: tb/tb_fifo_reg.sv
// Bench for fifo_reg: directed sequences with hand-computed values.
// Popped bytes are checked by a scoreboard monitor that runs on the en strobe.
module tb_fifo_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic       en;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] data_out;
  logic [7:0] reg0;
  logic [7:0] reg1;
  logic [7:0] reg2;
  logic [7:0] reg3;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];

  fifo_reg #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .en(en), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .data_out(data_out),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    chk({tag, ".reg0"}, reg0, a);
    chk({tag, ".reg1"}, reg1, b);
    chk({tag, ".reg2"}, reg2, c);
    chk({tag, ".reg3"}, reg3, d);
  endtask

  task automatic chk_flags(input string tag, input logic f, input logic e);
    chk({tag, ".full"}, fifo_full, f);
    chk({tag, ".empty"}, fifo_empty, e);
  endtask

  // One clock: apply the inputs, take the edge, then settle 1ns past it.
  task automatic cyc(input logic p, input logic q, input logic [7:0] d);
    push = p; pop = q; data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  // The expected byte is queued before the pop is issued.
  task automatic do_pop(input logic [7:0] expv);
    exp_q.push_back(expv);
    cyc(1'b0, 1'b1, 8'h00);
  endtask

  // Monitor: every en pulse must match the next queued byte.
  always @(negedge clk) begin
    if (en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected: en=1 data_out=%0h with nothing expected", data_out);
      end else begin
        chk("sb_data_out", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running after 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    chk_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("rst.data_out", data_out, 8'h00);
    chk("rst.en", en, 1'b0);
    chk_flags("rst", 1'b0, 1'b1);
    reset = 1'b1;

    cyc(1'b1, 1'b0, 8'd5);
    cyc(1'b1, 1'b0, 8'd9);
    cyc(1'b1, 1'b0, 8'd9);
    chk_regs("push3", 8'd5, 8'd9, 8'd9, 8'd0);
    chk_flags("push3", 1'b0, 1'b0);

    do_pop(8'd5);
    chk("pop1.en", en, 1'b1);
    chk("pop1.data_out", data_out, 8'd5);
    chk("pop1.reg0", reg0, 8'd9);
    chk("pop1.reg1", reg1, 8'd9);
    cyc(1'b1, 1'b0, 8'd45);
    chk("push45.reg2", reg2, 8'd45);
    chk("push45.en_drop", en, 1'b0);

    do_pop(8'd9);
    do_pop(8'd9);
    do_pop(8'd45);
    chk_flags("drain1", 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'd1);
    cyc(1'b1, 1'b0, 8'd2);
    cyc(1'b1, 1'b0, 8'd3);
    cyc(1'b1, 1'b0, 8'd4);
    chk_regs("fill", 8'd1, 8'd2, 8'd3, 8'd4);
    chk_flags("fill", 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'd7);
    chk_regs("drop7", 8'd1, 8'd2, 8'd3, 8'd4);
    chk_flags("drop7", 1'b1, 1'b0);
    exp_q.push_back(8'd1);
    cyc(1'b1, 1'b1, 8'd8);
    chk("pp_full.data_out", data_out, 8'd1);
    chk_regs("pp_full", 8'd2, 8'd3, 8'd4, 8'd8);
    chk_flags("pp_full", 1'b1, 1'b0);

    do_pop(8'd2);
    do_pop(8'd3);
    do_pop(8'd4);
    do_pop(8'd8);
    chk_flags("drain2", 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("pop_empty.en", en, 1'b0);
    chk("pop_empty.data_out", data_out, 8'd8);
    cyc(1'b1, 1'b1, 8'd6);
    chk("pp_empty.reg0", reg0, 8'd6);
    chk("pp_empty.en", en, 1'b0);
    chk("pp_empty.data_out", data_out, 8'd8);
    chk_flags("pp_empty", 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 8'd10);
    cyc(1'b1, 1'b0, 8'd11);
    cyc(1'b1, 1'b0, 8'd12);
    chk_regs("refill", 8'd6, 8'd10, 8'd11, 8'd12);
    do_pop(8'd6);
`ifdef FIFO_REG_CLEAR_ON_POP_EN
    chk_regs("vacate", 8'd10, 8'd11, 8'd12, 8'd0);
`else
    chk_regs("vacate", 8'd10, 8'd11, 8'd12, 8'd12);
`endif
    chk_flags("vacate", 1'b0, 1'b0);

    reset = 1'b0;
    cyc(1'b1, 1'b0, 8'd99);
    reset = 1'b1;
    chk_flags("midrst", 1'b0, 1'b1);
    chk("midrst.data_out", data_out, 8'd0);
    chk("midrst.en", en, 1'b0);
    chk_regs("midrst", 8'd0, 8'd0, 8'd0, 8'd0);

    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("sb_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
